// File: rtl/sdrc_wb_arbiter.sv
// rtl/sdrc_wb_arbiter.sv - two-master Wishbone arbiter with round-robin grant and ACK timeout abort
module sdrc_wb_arbiter #(
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            sdr_init_done,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);

    // Last stall count before the access is aborted; the abort fires on the
    // TIMEOUT-th consecutive unacknowledged strobe cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_gnt;
    logic        last_gnt_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;

    logic        granted;
    logic        own_cyc;
    logic        own_stb;
    logic        own_ack;
    logic        timeout_hit;
    logic        aborted_cyc;

    // Select the owning master's bus and form the slave-side pass-through
    always_comb begin
        granted  = (state == GNT0) || (state == GNT1);
        own_cyc  = (state == GNT1) ? m1_cyc_i : m0_cyc_i;
        own_stb  = (state == GNT1) ? m1_stb_i : m0_stb_i;

        s_cyc_o  = granted & own_cyc;
        s_stb_o  = granted & own_cyc & own_stb;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        if (state == GNT0) begin
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_sel_o = m0_sel_i;
            s_dat_o = m0_dat_i;
        end else if (state == GNT1) begin
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_sel_o = m1_sel_i;
            s_dat_o = m1_dat_i;
        end

        // The timeout only fires with s_ack_i low, so ack and err stay exclusive
        timeout_hit = s_stb_o & ~s_ack_i & (wait_cnt == WAIT_LAST);
        own_ack     = s_stb_o & s_ack_i;

        m0_ack_o = own_ack & (state == GNT0);
        m1_ack_o = own_ack & (state == GNT1);
        m0_err_o = timeout_hit & (state == GNT0);
        m1_err_o = timeout_hit & (state == GNT1);

        // Read data is broadcast; only the acked master samples it
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;

        gnt_o    = {state == GNT1, state == GNT0};

        // The aborted master is always the last one granted
        aborted_cyc = last_gnt ? m1_cyc_i : m0_cyc_i;
    end

    // Next-state, round-robin grant selection and stall counter
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        wait_cnt_nxt = '0;
        case (state)
            IDLE: begin
                if (sdr_init_done) begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        // Contention: favour the master not served last
                        state_nxt    = last_gnt ? GNT0 : GNT1;
                        last_gnt_nxt = ~last_gnt;
                    end else if (m0_cyc_i) begin
                        state_nxt    = GNT0;
                        last_gnt_nxt = 1'b0;
                    end else if (m1_cyc_i) begin
                        state_nxt    = GNT1;
                        last_gnt_nxt = 1'b1;
                    end
                end
            end
            GNT0, GNT1: begin
                if (timeout_hit) begin
                    state_nxt = ABORT;
                end else if (!own_cyc) begin
                    state_nxt = IDLE;
                end else if (s_stb_o && !s_ack_i) begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            ABORT: begin
                // Hold the port off until the aborted master ends its cycle
                if (!aborted_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, last grant and stall counter registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// tb/tb_sdrc_wb_arbiter.sv - self-checking bench for sdrc_wb_arbiter
module tb_sdrc_wb_arbiter;

    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [3:0]    m0_sel;
    logic [DW-1:0] m0_dat, m0_rdat;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [3:0]    m1_sel;
    logic [DW-1:0] m1_dat, m1_rdat;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [3:0]    s_sel;
    logic [DW-1:0] s_wdat, s_rdat;
    logic          s_ack;
    logic [1:0]    gnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdrc_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sdr_init_done(init),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel),
        .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether an abort is pending, and how
    // many consecutive strobe cycles have gone unanswered.
    int         m_owner;     // -1 none, else master index
    bit         m_abort;
    int         m_abort_m;
    int         m_last;
    int         m_stall;
    bit         m_tmo;
    logic [1:0] e_gnt;
    logic       e_scyc, e_sstb, e_a0, e_a1, e_e0, e_e1, e_we;
    logic [AW-1:0] e_adr;
    logic [3:0]    e_sel;
    logic [DW-1:0] e_dat;

    task automatic model_outputs();
        logic oc, os;
        e_gnt = 2'b00; e_scyc = 0; e_sstb = 0; e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0;
        e_we = 0; e_adr = '0; e_sel = '0; e_dat = '0; m_tmo = 0;
        if (!m_abort && m_owner >= 0) begin
            oc     = (m_owner == 1) ? m1_cyc : m0_cyc;
            os     = (m_owner == 1) ? m1_stb : m0_stb;
            e_gnt  = (m_owner == 1) ? 2'b10 : 2'b01;
            e_scyc = oc;
            e_sstb = oc & os;
            m_tmo  = e_sstb && !s_ack && (m_stall == TMO - 1);
            e_we   = (m_owner == 1) ? m1_we  : m0_we;
            e_adr  = (m_owner == 1) ? m1_adr : m0_adr;
            e_sel  = (m_owner == 1) ? m1_sel : m0_sel;
            e_dat  = (m_owner == 1) ? m1_dat : m0_dat;
            if (m_owner == 0) begin
                e_a0 = s_ack & e_sstb;
                e_e0 = m_tmo;
            end else begin
                e_a1 = s_ack & e_sstb;
                e_e1 = m_tmo;
            end
        end
    endtask

    task automatic model_update();
        model_outputs();
        if (rst) begin
            m_owner = -1; m_abort = 0; m_last = 1; m_stall = 0;
        end else if (m_abort) begin
            if (!((m_abort_m == 1) ? m1_cyc : m0_cyc)) m_abort = 0;
        end else if (m_owner < 0) begin
            if (init && (m0_cyc || m1_cyc)) begin
                if (m0_cyc && m1_cyc) m_owner = 1 - m_last;
                else                  m_owner = m0_cyc ? 0 : 1;
                m_last  = m_owner;
                m_stall = 0;
            end
        end else if (m_tmo) begin
            m_abort = 1; m_abort_m = m_owner; m_owner = -1; m_stall = 0;
        end else if (!e_scyc) begin
            m_owner = -1; m_stall = 0;
        end else begin
            m_stall = (e_sstb && !s_ack) ? m_stall + 1 : 0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
        next_cycle();
        rst = 0;
    endtask

    // in = {rst, init, c0, s0, c1, s1, ack}; exp = {gnt[1:0], s_cyc, a0, a1, e0, e1}
    typedef struct {
        logic [6:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[20];
    int   seq[6];

    initial begin
        int n;
        int ack_pct;
        logic prev_nz, req0, req1, nreq0, nreq1;

        tbl[0]  = '{7'b1111001, 7'b0000000};
        tbl[1]  = '{7'b1111001, 7'b0000000};
        tbl[2]  = '{7'b0111001, 7'b0000000};
        tbl[3]  = '{7'b0111001, 7'b0111000};
        tbl[4]  = '{7'b0111110, 7'b0110000};
        tbl[5]  = '{7'b0100110, 7'b0100000};
        tbl[6]  = '{7'b0100110, 7'b0000000};
        tbl[7]  = '{7'b0100111, 7'b1010100};
        for (int i = 8; i <= 14; i++) tbl[i] = '{7'b0111110, 7'b1010000};
        tbl[15] = '{7'b0111110, 7'b1010001};
        tbl[16] = '{7'b0111111, 7'b0000000};
        tbl[17] = '{7'b0111000, 7'b0000000};
        tbl[18] = '{7'b0111000, 7'b0000000};
        tbl[19] = '{7'b0111001, 7'b0111000};

        init = 1; m0_we = 0; m1_we = 0; m0_adr = '0; m1_adr = '0;
        m0_sel = 4'hf; m1_sel = 4'hf; m0_dat = '0; m1_dat = '0; s_rdat = '0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 0; m1_stb = 0; s_ack = 1; rst = 1;
        next_cycle();

        // Directed table: reset with requests, grants, pass-through ack, timeout abort
        for (int i = 0; i < 20; i++) begin
            {rst, init, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = tbl[i].in;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i),   64'(gnt),    64'(tbl[i].exp[6:5]));
            chk($sformatf("tbl%0d_scyc", i),  64'(s_cyc),  64'(tbl[i].exp[4]));
            chk($sformatf("tbl%0d_ack0", i),  64'(m0_ack), 64'(tbl[i].exp[3]));
            chk($sformatf("tbl%0d_ack1", i),  64'(m1_ack), 64'(tbl[i].exp[2]));
            chk($sformatf("tbl%0d_err0", i),  64'(m0_err), 64'(tbl[i].exp[1]));
            chk($sformatf("tbl%0d_err1", i),  64'(m1_err), 64'(tbl[i].exp[0]));
            next_cycle();
        end

        // Grants held off while initialisation is incomplete
        init = 0;
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("init_hold_gnt", 64'(gnt), 64'(2'b00));
            next_cycle();
        end
        init = 1;
        @(negedge clk);
        chk("init_edge_gnt", 64'(gnt), 64'(2'b00));
        next_cycle();
        @(negedge clk);
        chk("init_grant_gnt", 64'(gnt), 64'(2'b10));
        chk("init_grant_scyc", 64'(s_cyc), 64'(1'b1));
        m1_cyc = 0; m1_stb = 0;
        next_cycle();

        // Simultaneous requests, 4-beat reads each
        do_reset();
        m0_adr = 26'h100; m1_adr = 26'h200; s_ack = 1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clk);
        chk("cont_idle_gnt", 64'(gnt), 64'(2'b00));
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            s_rdat = 32'ha000_0000 + 32'(i);
            @(negedge clk);
            chk("cont_m0_gnt", 64'(gnt), 64'(2'b01));
            chk("cont_m0_adr", 64'(s_adr), 64'h100);
            chk("cont_m0_ack", 64'(m0_ack), 64'(1'b1));
            chk("cont_m0_noack1", 64'(m1_ack), 64'(1'b0));
            chk("cont_m0_data", 64'(m0_rdat), 64'(32'ha000_0000 + 32'(i)));
            next_cycle();
        end
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        chk("cont_rel_scyc", 64'(s_cyc), 64'(1'b0));
        next_cycle();
        @(negedge clk);
        chk("cont_gap_gnt", 64'(gnt), 64'(2'b00));
        chk("cont_gap_scyc", 64'(s_cyc), 64'(1'b0));
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            s_rdat = 32'hb000_0000 + 32'(i);
            @(negedge clk);
            chk("cont_m1_gnt", 64'(gnt), 64'(2'b10));
            chk("cont_m1_adr", 64'(s_adr), 64'h200);
            chk("cont_m1_ack", 64'(m1_ack), 64'(1'b1));
            chk("cont_m1_noack0", 64'(m0_ack), 64'(1'b0));
            chk("cont_m1_data", 64'(m1_rdat), 64'(32'hb000_0000 + 32'(i)));
            next_cycle();
        end
        m1_cyc = 0; m1_stb = 0;
        next_cycle();

        // Both masters keep re-requesting: grants must alternate
        do_reset();
        s_ack = 1; req0 = 1; req1 = 1; prev_nz = 0; n = 0;
        for (int c = 0; c < 60; c++) begin
            m0_cyc = req0; m0_stb = req0; m1_cyc = req1; m1_stb = req1;
            @(negedge clk);
            if (gnt != 2'b00 && !prev_nz && n < 6) begin
                seq[n] = (gnt == 2'b01) ? 0 : 1;
                n++;
            end
            prev_nz = (gnt != 2'b00);
            nreq0 = !(req0 && m0_ack);
            nreq1 = !(req1 && m1_ack);
            next_cycle();
            req0 = nreq0; req1 = nreq1;
        end
        chk("alt_count", 64'(n), 64'(6));
        for (int i = 0; i < n; i++) chk($sformatf("alt_grant%0d", i), 64'(seq[i]), 64'(i % 2));
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        next_cycle();

        // 10-beat write by m0 while m1 waits
        do_reset();
        s_ack = 1; m0_we = 1; m0_cyc = 1; m0_stb = 1;
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            m1_cyc = 1; m1_stb = 1;
            m0_dat = 32'h5000_0000 + 32'(i);
            @(negedge clk);
            chk("wr_gnt", 64'(gnt), 64'(2'b01));
            chk("wr_ack0", 64'(m0_ack), 64'(1'b1));
            chk("wr_noack1", 64'(m1_ack), 64'(1'b0));
            chk("wr_we", 64'(s_we), 64'(1'b1));
            chk("wr_dat", 64'(s_wdat), 64'(32'h5000_0000 + 32'(i)));
            next_cycle();
        end
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        chk("wr_rel_ack1", 64'(m1_ack), 64'(1'b0));
        next_cycle();
        @(negedge clk);
        chk("wr_gap_gnt", 64'(gnt), 64'(2'b00));
        next_cycle();
        @(negedge clk);
        chk("wr_m1_gnt", 64'(gnt), 64'(2'b10));
        chk("wr_m1_ack", 64'(m1_ack), 64'(1'b1));
        m1_cyc = 0; m1_stb = 0; m0_we = 0;
        next_cycle();

        // Randomised traffic against the reference model
        do_reset();
        ack_pct = 40;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 5;
                    1:       ack_pct = 40;
                    default: ack_pct = 90;
                endcase
            end
            rst  = ($urandom_range(0, 299) == 0);
            init = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
            m0_stb = ($urandom_range(0, 3) != 0);
            m1_stb = ($urandom_range(0, 3) != 0);
            m0_we  = 1'($urandom); m1_we = 1'($urandom);
            m0_adr = AW'($urandom); m1_adr = AW'($urandom);
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            m0_dat = $urandom; m1_dat = $urandom; s_rdat = $urandom;
            s_ack  = ($urandom_range(0, 99) < ack_pct);
            @(negedge clk);
            model_outputs();
            chk("rnd_gnt",  64'(gnt),    64'(e_gnt));
            chk("rnd_scyc", 64'(s_cyc),  64'(e_scyc));
            chk("rnd_sstb", 64'(s_stb),  64'(e_sstb));
            chk("rnd_ack0", 64'(m0_ack), 64'(e_a0));
            chk("rnd_ack1", 64'(m1_ack), 64'(e_a1));
            chk("rnd_err0", 64'(m0_err), 64'(e_e0));
            chk("rnd_err1", 64'(m1_err), 64'(e_e1));
            chk("rnd_rdat0", 64'(m0_rdat), 64'(s_rdat));
            chk("rnd_rdat1", 64'(m1_rdat), 64'(s_rdat));
            if (e_scyc) begin
                chk("rnd_adr", 64'(s_adr),  64'(e_adr));
                chk("rnd_we",  64'(s_we),   64'(e_we));
                chk("rnd_sel", 64'(s_sel),  64'(e_sel));
                chk("rnd_dat", 64'(s_wdat), 64'(e_dat));
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
